alu_rs: RTL and testbench

ALU_RS -- requirements
Module: alu_rs

---
 rtl/alu_rs.sv | 199 +++++++++++++++++++
 tb/tb_alu_rs.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rs.sv
// alu_rs: LC-3b ALU reservation station with CDB wakeup and single combinational issue.
// Optional macro ALU_RS_AGE_SELECT_EN: issue the oldest ready entry via compacting age ranks.
package alu_rs_pkg;
   typedef enum logic [2:0] {
      alu_add, alu_and, alu_not, alu_pass, alu_sll, alu_srl, alu_sra
   } lc3b_aluop;
endpackage

module alu_rs
   import alu_rs_pkg::*;
#(
   parameter int unsigned NUM_ENTRIES = 4,
   parameter int unsigned TAG_WIDTH   = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 dispatch_valid,
   input  lc3b_aluop            dispatch_aluop,
   input  logic [15:0]          dispatch_vj,
   input  logic [15:0]          dispatch_vk,
   input  logic                 dispatch_qj_valid,
   input  logic                 dispatch_qk_valid,
   input  logic [TAG_WIDTH-1:0] dispatch_qj,
   input  logic [TAG_WIDTH-1:0] dispatch_qk,
   input  logic [TAG_WIDTH-1:0] dispatch_dest,
   output logic                 rs_full,
   input  logic                 cdb_valid,
   input  logic [TAG_WIDTH-1:0] cdb_tag,
   input  logic [15:0]          cdb_value,
   input  logic                 alu_ready,
   output logic                 issue_valid,
   output lc3b_aluop            issue_aluop,
   output logic [15:0]          issue_a,
   output logic [15:0]          issue_b,
   output logic [TAG_WIDTH-1:0] issue_dest
);
   localparam int unsigned DATA_W = 16;
   localparam int unsigned IDX_W  = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

   logic [NUM_ENTRIES-1:0] busy_q, busy_d, qjv_q, qjv_d, qkv_q, qkv_d, ready;
   lc3b_aluop              aluop_q [NUM_ENTRIES];
   lc3b_aluop              aluop_d [NUM_ENTRIES];
   logic [DATA_W-1:0]      vj_q [NUM_ENTRIES];
   logic [DATA_W-1:0]      vj_d [NUM_ENTRIES];
   logic [DATA_W-1:0]      vk_q [NUM_ENTRIES];
   logic [DATA_W-1:0]      vk_d [NUM_ENTRIES];
   logic [TAG_WIDTH-1:0]   qj_q [NUM_ENTRIES];
   logic [TAG_WIDTH-1:0]   qj_d [NUM_ENTRIES];
   logic [TAG_WIDTH-1:0]   qk_q [NUM_ENTRIES];
   logic [TAG_WIDTH-1:0]   qk_d [NUM_ENTRIES];
   logic [TAG_WIDTH-1:0]   dest_q [NUM_ENTRIES];
   logic [TAG_WIDTH-1:0]   dest_d [NUM_ENTRIES];

   logic [IDX_W-1:0] sel_idx, free_idx;
   logic             sel_found, free_found, disp_accept, issue_fire;

   assign ready       = busy_q & ~qjv_q & ~qkv_q;
   assign rs_full     = &busy_q;
   assign disp_accept = dispatch_valid && free_found && !flush;
   assign issue_fire  = sel_found && alu_ready;

   assign issue_valid = sel_found;
   assign issue_aluop = aluop_q[sel_idx];
   assign issue_a     = vj_q[sel_idx];
   assign issue_b     = vk_q[sel_idx];
   assign issue_dest  = dest_q[sel_idx];

   // Lowest-index free entry for dispatch
   always_comb begin
      free_idx   = '0;
      free_found = 1'b0;
      for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
         if (!busy_q[i] && !free_found) begin
            free_idx   = IDX_W'(i);
            free_found = 1'b1;
         end
      end
   end

`ifdef ALU_RS_AGE_SELECT_EN
   localparam int unsigned CNT_W = $clog2(NUM_ENTRIES + 1);

   // Rank 0 is the oldest entry; ranks of busy entries are always 0..count-1
   logic [IDX_W-1:0] age_q [NUM_ENTRIES];
   logic [IDX_W-1:0] age_d [NUM_ENTRIES];
   logic [IDX_W-1:0] best_age;
   logic [CNT_W-1:0] busy_cnt;

   always_comb begin
      sel_idx   = '0;
      sel_found = 1'b0;
      best_age  = '0;
      for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
         if (ready[i] && (!sel_found || age_q[i] < best_age)) begin
            sel_idx   = IDX_W'(i);
            sel_found = 1'b1;
            best_age  = age_q[i];
         end
      end
   end

   always_comb begin
      busy_cnt = '0;
      for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
         busy_cnt = busy_cnt + CNT_W'(busy_q[i]);
      end
      age_d = age_q;
      if (issue_fire) begin
         for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
            if (busy_q[i] && age_q[i] > best_age) age_d[i] = age_q[i] - IDX_W'(1);
         end
      end
      if (disp_accept) age_d[free_idx] = IDX_W'(busy_cnt - CNT_W'(issue_fire));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(NUM_ENTRIES); i++) age_q[i] <= '0;
      end else begin
         age_q <= age_d;
      end
   end
`else
   always_comb begin
      sel_idx   = '0;
      sel_found = 1'b0;
      for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
         if (ready[i] && !sel_found) begin
            sel_idx   = IDX_W'(i);
            sel_found = 1'b1;
         end
      end
   end
`endif

   // Next state: CDB wakeup, issue free, dispatch with same-cycle capture, flush last
   always_comb begin
      busy_d  = busy_q;
      qjv_d   = qjv_q;
      qkv_d   = qkv_q;
      aluop_d = aluop_q;
      vj_d    = vj_q;
      vk_d    = vk_q;
      qj_d    = qj_q;
      qk_d    = qk_q;
      dest_d  = dest_q;
      for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
         if (cdb_valid && busy_q[i] && qjv_q[i] && qj_q[i] == cdb_tag) begin
            vj_d[i]  = cdb_value;
            qjv_d[i] = 1'b0;
         end
         if (cdb_valid && busy_q[i] && qkv_q[i] && qk_q[i] == cdb_tag) begin
            vk_d[i]  = cdb_value;
            qkv_d[i] = 1'b0;
         end
      end
      if (issue_fire) busy_d[sel_idx] = 1'b0;
      if (disp_accept) begin
         busy_d[free_idx]  = 1'b1;
         aluop_d[free_idx] = dispatch_aluop;
         dest_d[free_idx]  = dispatch_dest;
         qj_d[free_idx]    = dispatch_qj;
         qk_d[free_idx]    = dispatch_qk;
         qjv_d[free_idx]   = dispatch_qj_valid && !(cdb_valid && cdb_tag == dispatch_qj);
         qkv_d[free_idx]   = dispatch_qk_valid && !(cdb_valid && cdb_tag == dispatch_qk);
         vj_d[free_idx]    = dispatch_qj_valid ? cdb_value : dispatch_vj;
         vk_d[free_idx]    = dispatch_qk_valid ? cdb_value : dispatch_vk;
      end
      if (flush) busy_d = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= '0;
         qjv_q  <= '0;
         qkv_q  <= '0;
         for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
            aluop_q[i] <= alu_add;
            vj_q[i]    <= '0;
            vk_q[i]    <= '0;
            qj_q[i]    <= '0;
            qk_q[i]    <= '0;
            dest_q[i]  <= '0;
         end
      end else begin
         busy_q  <= busy_d;
         qjv_q   <= qjv_d;
         qkv_q   <= qkv_d;
         aluop_q <= aluop_d;
         vj_q    <= vj_d;
         vk_q    <= vk_d;
         qj_q    <= qj_d;
         qk_q    <= qk_d;
         dest_q  <= dest_d;
      end
   end

endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: directed and random checks of alu_rs against an entry-list reference model.
// Honors ALU_RS_AGE_SELECT_EN for the expected issue order.
module tb_alu_rs;
   import alu_rs_pkg::*;

   localparam int NE = 4;
   localparam int TW = 3;

   logic          clk, rst, flush;
   logic          dispatch_valid;
   lc3b_aluop     dispatch_aluop;
   logic [15:0]   dispatch_vj, dispatch_vk;
   logic          dispatch_qj_valid, dispatch_qk_valid;
   logic [TW-1:0] dispatch_qj, dispatch_qk, dispatch_dest;
   logic          rs_full;
   logic          cdb_valid;
   logic [TW-1:0] cdb_tag;
   logic [15:0]   cdb_value;
   logic          alu_ready;
   logic          issue_valid;
   lc3b_aluop     issue_aluop;
   logic [15:0]   issue_a, issue_b;
   logic [TW-1:0] issue_dest;

   int errors = 0;
   int checks = 0;

   alu_rs #(.NUM_ENTRIES(NE), .TAG_WIDTH(TW)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .dispatch_valid(dispatch_valid), .dispatch_aluop(dispatch_aluop),
      .dispatch_vj(dispatch_vj), .dispatch_vk(dispatch_vk),
      .dispatch_qj_valid(dispatch_qj_valid), .dispatch_qk_valid(dispatch_qk_valid),
      .dispatch_qj(dispatch_qj), .dispatch_qk(dispatch_qk), .dispatch_dest(dispatch_dest),
      .rs_full(rs_full), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
      .alu_ready(alu_ready), .issue_valid(issue_valid), .issue_aluop(issue_aluop),
      .issue_a(issue_a), .issue_b(issue_b), .issue_dest(issue_dest)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: one record per slot, age as a global dispatch sequence number
   typedef struct {
      bit          busy;
      lc3b_aluop   op;
      logic [15:0] vj, vk;
      bit          qjv, qkv;
      logic [TW-1:0] qj, qk, dest;
      int          seq;
   } ent_t;

   ent_t m [NE];
   int   seq_ctr = 0;

   function automatic void model_reset();
      for (int i = 0; i < NE; i++) m[i].busy = 0;
   endfunction

   function automatic int model_sel();
      int best = -1;
      for (int i = 0; i < NE; i++) begin
         if (m[i].busy && !m[i].qjv && !m[i].qkv) begin
`ifdef ALU_RS_AGE_SELECT_EN
            if (best < 0 || m[i].seq < m[best].seq) best = i;
`else
            if (best < 0) best = i;
`endif
         end
      end
      return best;
   endfunction

   function automatic void model_edge();
      ent_t nm [NE];
      int   s, fr;
      nm = m;
      s  = model_sel();
      fr = -1;
      for (int i = 0; i < NE; i++) begin
         if (!m[i].busy && fr < 0) fr = i;
         if (m[i].busy && cdb_valid && m[i].qjv && m[i].qj == cdb_tag) begin
            nm[i].qjv = 0; nm[i].vj = cdb_value;
         end
         if (m[i].busy && cdb_valid && m[i].qkv && m[i].qk == cdb_tag) begin
            nm[i].qkv = 0; nm[i].vk = cdb_value;
         end
      end
      if (s >= 0 && alu_ready) nm[s].busy = 0;
      if (dispatch_valid && !flush && fr >= 0) begin
         nm[fr].busy = 1;
         nm[fr].op   = dispatch_aluop;
         nm[fr].dest = dispatch_dest;
         nm[fr].seq  = seq_ctr;
         seq_ctr++;
         nm[fr].qj = dispatch_qj;
         nm[fr].qk = dispatch_qk;
         if (dispatch_qj_valid && !(cdb_valid && cdb_tag == dispatch_qj)) nm[fr].qjv = 1;
         else begin
            nm[fr].qjv = 0;
            nm[fr].vj  = dispatch_qj_valid ? cdb_value : dispatch_vj;
         end
         if (dispatch_qk_valid && !(cdb_valid && cdb_tag == dispatch_qk)) nm[fr].qkv = 1;
         else begin
            nm[fr].qkv = 0;
            nm[fr].vk  = dispatch_qk_valid ? cdb_value : dispatch_vk;
         end
      end
      if (flush) for (int i = 0; i < NE; i++) nm[i].busy = 0;
      m = nm;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic compare();
      int  s;
      bit  full;
      s    = model_sel();
      full = 1;
      for (int i = 0; i < NE; i++) if (!m[i].busy) full = 0;
      chk("rs_full", 32'(rs_full), 32'(full));
      chk("issue_valid", 32'(issue_valid), 32'(s >= 0));
      if (s >= 0) begin
         chk("issue_aluop", 32'(issue_aluop), 32'(m[s].op));
         chk("issue_a", 32'(issue_a), 32'(m[s].vj));
         chk("issue_b", 32'(issue_b), 32'(m[s].vk));
         chk("issue_dest", 32'(issue_dest), 32'(m[s].dest));
      end
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      compare();
      dispatch_valid = 0;
      cdb_valid      = 0;
      flush          = 0;
   endtask

   task automatic disp(input lc3b_aluop op, input logic [15:0] vj, input logic [15:0] vk,
                       input bit qjv, input logic [TW-1:0] qj,
                       input bit qkv, input logic [TW-1:0] qk, input logic [TW-1:0] dest);
      dispatch_valid    = 1;
      dispatch_aluop    = op;
      dispatch_vj       = vj;
      dispatch_vk       = vk;
      dispatch_qj_valid = qjv;
      dispatch_qj       = qj;
      dispatch_qk_valid = qkv;
      dispatch_qk       = qk;
      dispatch_dest     = dest;
   endtask

   task automatic bcast(input logic [TW-1:0] tag, input logic [15:0] val);
      cdb_valid = 1;
      cdb_tag   = tag;
      cdb_value = val;
   endtask

   initial begin
      rst = 1; flush = 0; dispatch_valid = 0; dispatch_aluop = alu_add;
      dispatch_vj = 0; dispatch_vk = 0; dispatch_qj_valid = 0; dispatch_qk_valid = 0;
      dispatch_qj = 0; dispatch_qk = 0; dispatch_dest = 0;
      cdb_valid = 0; cdb_tag = 0; cdb_value = 0; alu_ready = 0;
      model_reset();
      #1;
      chk("reset_full", 32'(rs_full), 32'd0);
      chk("reset_valid", 32'(issue_valid), 32'd0);
      @(posedge clk); @(posedge clk); #1;
      rst = 0;

      // Fill with four ready ADDs, then a refused fifth
      for (int i = 1; i <= 4; i++) begin
         disp(alu_add, 16'(i), 16'd10, 0, 0, 0, 0, 3'(i));
         step();
      end
      chk("fill_full", 32'(rs_full), 32'd1);
      disp(alu_add, 16'd5, 16'd10, 0, 0, 0, 0, 3'd5);
      step();
      chk("fill_refused_a", 32'(issue_a), 32'd1);
      alu_ready = 1;
      for (int i = 0; i < 4; i++) step();
      chk("fill_drained", 32'(issue_valid), 32'd0);

      // Wakeup of a pending source operand
      alu_ready = 0;
      disp(alu_and, 16'h0000, 16'h00FF, 1, 3'd2, 0, 0, 3'd1);
      step();
      chk("wake_wait", 32'(issue_valid), 32'd0);
      bcast(3'd2, 16'h1234);
      step();
      chk("wake_valid", 32'(issue_valid), 32'd1);
      chk("wake_a", 32'(issue_a), 32'h1234);
      chk("wake_b", 32'(issue_b), 32'h00FF);
      chk("wake_op", 32'(issue_aluop), 32'(alu_and));
      alu_ready = 1;
      step();

      // Same-cycle capture, then stall three cycles and release
      alu_ready = 0;
      disp(alu_pass, 16'h0003, 16'h0000, 0, 0, 1, 3'd5, 3'd2);
      bcast(3'd5, 16'h0007);
      step();
      chk("capture_b", 32'(issue_b), 32'h0007);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_b", 32'(issue_b), 32'h0007);
         chk("stall_op", 32'(issue_aluop), 32'(alu_pass));
      end
      alu_ready = 1;
      step();
      chk("stall_freed", 32'(issue_valid), 32'd0);

      // Ordering: entry 2 dispatched before entry 0, both ready
      alu_ready = 0;
      disp(alu_add, 16'h000A, 16'd0, 0, 0, 0, 0, 3'd0);
      step();
      disp(alu_add, 16'h0011, 16'd0, 1, 3'd6, 0, 0, 3'd1);
      step();
      alu_ready = 1;
      disp(alu_add, 16'h0022, 16'd0, 0, 0, 0, 0, 3'd2);
      step();
      alu_ready = 0;
      disp(alu_add, 16'h0033, 16'd0, 0, 0, 0, 0, 3'd3);
      step();
`ifdef ALU_RS_AGE_SELECT_EN
      chk("order_first", 32'(issue_a), 32'h0022);
`else
      chk("order_first", 32'(issue_a), 32'h0033);
`endif
      alu_ready = 1;
      step();
`ifdef ALU_RS_AGE_SELECT_EN
      chk("order_second", 32'(issue_a), 32'h0033);
`else
      chk("order_second", 32'(issue_a), 32'h0022);
`endif
      step();
      bcast(3'd6, 16'h0044);
      step();
      chk("order_late", 32'(issue_a), 32'h0044);
      step();

      // Flush beats a same-cycle dispatch
      alu_ready = 0;
      disp(alu_not, 16'h1111, 16'd0, 0, 0, 0, 0, 3'd4);
      step();
      disp(alu_sll, 16'h2222, 16'd1, 0, 0, 0, 0, 3'd5);
      flush = 1;
      step();
      chk("flush_valid", 32'(issue_valid), 32'd0);
      chk("flush_full", 32'(rs_full), 32'd0);

      // Asynchronous reset between edges on a full station
      for (int i = 0; i < 4; i++) begin
         disp(alu_srl, 16'(i + 16'h40), 16'd2, 0, 0, 0, 0, 3'(i));
         step();
      end
      chk("prerst_full", 32'(rs_full), 32'd1);
      #2 rst = 1;
      #1;
      chk("rst_async_valid", 32'(issue_valid), 32'd0);
      chk("rst_async_full", 32'(rs_full), 32'd0);
      model_reset();
      #1 rst = 0;

      // Random traffic against the model
      for (int n = 0; n < 500; n++) begin
         alu_ready = ($urandom_range(0, 9) < 6);
         if ($urandom_range(0, 9) < 6)
            disp(lc3b_aluop'($urandom_range(0, 6)), 16'($urandom), 16'($urandom),
                 ($urandom_range(0, 9) < 3), 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 9) < 3), 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)));
         if ($urandom_range(0, 1) == 1) bcast(3'($urandom_range(0, 7)), 16'($urandom));
         flush = ($urandom_range(0, 49) == 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
